// File: rtl/hazard_stall_if.sv
// hazard_stall_if: pipeline-side bundle between the datapath and the hazard/stall controller.
interface hazard_stall_if;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        flush;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;
    logic        stall_pc;
    logic        stall_fd;
    logic        stall_dx;
    logic        nop_dx;
    logic        nop_xm;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] pw_result;
    logic        pw_exception;
    logic        pw_valid;
    logic        md_busy;

    modport master (
        output fd_ir, dx_ir, flush, md_resultRDY, md_result, md_exception,
        input  stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, ctrl_MULT, ctrl_DIV,
               pw_result, pw_exception, pw_valid, md_busy
    );

    modport slave (
        input  fd_ir, dx_ir, flush, md_resultRDY, md_result, md_exception,
        output stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, ctrl_MULT, ctrl_DIV,
               pw_result, pw_exception, pw_valid, md_busy
    );
endinterface

// File: rtl/hazard_stall.sv
// hazard_stall: load-use stall detection and mult/div sequencing with a P/W result holding register.
// Optional HAZARD_MD_TIMEOUT_EN adds a 64-cycle BUSY watchdog that retires with an exception.
module hazard_stall (
    input logic           clock,
    input logic           reset,
    hazard_stall_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      stateQ, stateD;
    logic [4:0]  fdOp, fdRd, fdRs, fdRt, dxOp, dxRd, dxAlu;
    logic        dxIsMd, loadUse, start, hold, finish, timeout;
    logic [31:0] pwResult;
    logic        pwException;
    logic        unusedBits;

    assign fdOp  = bus.fd_ir[31:27];
    assign fdRd  = bus.fd_ir[26:22];
    assign fdRs  = bus.fd_ir[21:17];
    assign fdRt  = bus.fd_ir[16:12];
    assign dxOp  = bus.dx_ir[31:27];
    assign dxRd  = bus.dx_ir[26:22];
    assign dxAlu = bus.dx_ir[6:2];
    assign unusedBits = ^{bus.fd_ir[11:0], bus.dx_ir[21:7], bus.dx_ir[1:0]};

    assign dxIsMd = dxOp == 5'b00000 && dxAlu[4:1] == 4'b0011;

    // sw is left out of the rd readers: its store data is bypassed in memory
    assign loadUse = stateQ == IDLE && !bus.flush && dxOp == 5'b01000 && dxRd != 5'd0 &&
                     (fdRs == dxRd || (fdOp == 5'b00000 && fdRt == dxRd) ||
                      ((fdOp == 5'b00010 || fdOp == 5'b00110 || fdOp == 5'b00100) && fdRd == dxRd));

    always_comb begin
        start  = stateQ == IDLE && dxIsMd;
        hold   = start || stateQ == BUSY;
        finish = stateQ == BUSY && (bus.md_resultRDY || timeout);
        stateD = start ? BUSY : finish ? DONE : stateQ == DONE ? IDLE : stateQ;
    end

    always_ff @(posedge clock)
        stateQ <= reset ? IDLE : stateD;

`ifdef HAZARD_MD_TIMEOUT_EN
    logic [5:0] busyCount;

    assign timeout = busyCount == 6'd63;

    always_ff @(posedge clock)
        busyCount <= (reset || start) ? 6'd0 : stateQ == BUSY ? busyCount + 6'd1 : busyCount;
`else
    assign timeout = 1'b0;
`endif

    // a real result beats the watchdog when both land in the same cycle
    always_ff @(posedge clock)
        if (reset)
            {pwResult, pwException} <= '0;
        else if (finish)
            {pwResult, pwException} <= bus.md_resultRDY ? {bus.md_result, bus.md_exception} : {32'd0, 1'b1};

    assign bus.stall_pc     = hold || loadUse;
    assign bus.stall_fd     = hold || loadUse;
    assign bus.stall_dx     = hold;
    assign bus.nop_dx       = loadUse;
    assign bus.nop_xm       = hold;
    assign bus.ctrl_MULT    = start && !dxAlu[0];
    assign bus.ctrl_DIV     = start && dxAlu[0];
    assign bus.pw_result    = pwResult;
    assign bus.pw_exception = pwException;
    assign bus.pw_valid     = stateQ == DONE;
    assign bus.md_busy      = stateQ != IDLE;
endmodule

// File: tb/tb_hazard_stall.sv
// tb_hazard_stall: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_hazard_stall;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hazard_stall_if bus();

    hazard_stall dut (.clock(clock), .reset(reset), .bus(bus));

    // control vector order: {stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, ctrl_MULT, ctrl_DIV, pw_valid, md_busy}
    localparam logic [8:0] ZERO = 9'b000_00_00_00;
    localparam logic [8:0] LU   = 9'b110_10_00_00;
    localparam logic [8:0] SMUL = 9'b111_01_10_00;
    localparam logic [8:0] SDIV = 9'b111_01_01_00;
    localparam logic [8:0] WAIT = 9'b111_01_00_01;
    localparam logic [8:0] FIN  = 9'b000_00_00_11;
    localparam logic [4:0] OPS [7] = '{5'd0, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd5};
`ifdef HAZARD_MD_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 0;
`endif

    logic [8:0] act;
    assign act = {bus.stall_pc, bus.stall_fd, bus.stall_dx, bus.nop_dx, bus.nop_xm,
                  bus.ctrl_MULT, bus.ctrl_DIV, bus.pw_valid, bus.md_busy};

    function automatic logic [31:0] mkIr(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    localparam logic [31:0] NOP  = 32'd0;
    localparam logic [31:0] MULT = {5'd0, 5'd4, 5'd2, 5'd3, 5'd0, 5'd6, 2'b00};
    localparam logic [31:0] DIV  = {5'd0, 5'd6, 5'd2, 5'd0, 5'd0, 5'd7, 2'b00};

    // behavioural model: an instruction either waits in the unit, is retiring, or nothing is outstanding
    bit          mInFlight = 0;
    bit          mRetire = 0;
    int          mWait = 0;
    logic [31:0] mPwRes = 0;
    logic        mPwExc = 0;

    function automatic logic [31:0] readMask(logic [31:0] ir);
        logic [31:0] m = 0;
        m[ir[21:17]] = 1'b1;
        if (ir[31:27] == 5'd0) m[ir[16:12]] = 1'b1;
        if (ir[31:27] == 5'd2 || ir[31:27] == 5'd6 || ir[31:27] == 5'd4) m[ir[26:22]] = 1'b1;
        return m;
    endfunction

    function automatic logic [8:0] expCtl();
        logic [31:0] m = readMask(bus.fd_ir);
        logic [4:0] d = bus.dx_ir[26:22];
        logic [4:0] alu = bus.dx_ir[6:2];
        bit quiet = !mInFlight && !mRetire;
        bit lu = quiet && !bus.flush && bus.dx_ir[31:27] == 5'd8 && d != 0 && m[d];
        bit st = quiet && bus.dx_ir[31:27] == 5'd0 && (alu == 5'd6 || alu == 5'd7);
        bit hd = st || mInFlight;
        return {hd | lu, hd | lu, hd, lu, hd, st && alu == 5'd6, st && alu == 5'd7, mRetire, mInFlight | mRetire};
    endfunction

    always @(posedge clock) begin
        logic [8:0] e;
        e = expCtl();
        if (reset) begin
            mInFlight = 0; mRetire = 0; mWait = 0; mPwRes = 0; mPwExc = 0;
        end else if (mRetire) begin
            mRetire = 0;
        end else if (mInFlight) begin
            mWait++;
            if (bus.md_resultRDY) begin
                mPwRes = bus.md_result; mPwExc = bus.md_exception; mInFlight = 0; mRetire = 1;
            end else if (TMO != 0 && mWait == TMO) begin
                mPwRes = 0; mPwExc = 1; mInFlight = 0; mRetire = 1;
            end
        end else if (e[3] || e[2]) begin
            mInFlight = 1; mWait = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; bus.fd_ir = NOP; bus.dx_ir = NOP; bus.flush = 0;
        bus.md_resultRDY = 0; bus.md_result = 0; bus.md_exception = 0;
        repeat (2) tick();
        @(negedge clock);
        checks++;
        if (act !== ZERO || bus.pw_result !== 32'd0 || bus.pw_exception !== 1'b0) begin
            errors++;
            $display("FAIL reset: ctl=%b pw=%h exc=%b, expected ctl=%b pw=0 exc=0", act, bus.pw_result, bus.pw_exception, ZERO);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_load_use();
        bus.dx_ir = mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0);
        bus.fd_ir = mkIr(5'd0, 5'd3, 5'd5, 5'd2, 5'd0);
        @(negedge clock);
        checks++;
        if (act !== LU) begin errors++; $display("FAIL load_use: ctl=%b expected %b", act, LU); end
        tick();
        bus.flush = 1;
        @(negedge clock);
        checks++;
        if (act !== ZERO) begin errors++; $display("FAIL load_use_flush: ctl=%b expected %b", act, ZERO); end
        tick();
        bus.flush = 0; bus.dx_ir = NOP;
        @(negedge clock);
        checks++;
        if (act !== ZERO) begin errors++; $display("FAIL load_use_after: ctl=%b expected %b", act, ZERO); end
        tick();
    endtask

    task automatic test_store_exempt();
        logic [31:0] fds [7];
        logic [31:0] dxs [7];
        logic [8:0]  exps [7];
        fds = '{mkIr(5'd7, 5'd5, 5'd2, 5'd0, 5'd0), mkIr(5'd7, 5'd3, 5'd5, 5'd0, 5'd0),
                mkIr(5'd0, 5'd3, 5'd0, 5'd0, 5'd0), mkIr(5'd2, 5'd5, 5'd1, 5'd0, 5'd0),
                mkIr(5'd5, 5'd3, 5'd1, 5'd5, 5'd0), mkIr(5'd4, 5'd5, 5'd0, 5'd0, 5'd0),
                mkIr(5'd0, 5'd3, 5'd1, 5'd5, 5'd0)};
        dxs = '{mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0),
                mkIr(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0),
                mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0),
                mkIr(5'd8, 5'd5, 5'd1, 5'd0, 5'd0)};
        exps = '{ZERO, LU, ZERO, LU, ZERO, LU, LU};
        for (int i = 0; i < 7; i++) begin
            bus.fd_ir = fds[i]; bus.dx_ir = dxs[i];
            @(negedge clock);
            checks++;
            if (act !== exps[i]) begin errors++; $display("FAIL source_decode[%0d]: ctl=%b expected %b", i, act, exps[i]); end
            tick();
        end
        bus.fd_ir = NOP; bus.dx_ir = NOP;
        tick();
    endtask

    task automatic test_mult();
        int pulses = 0, busy = 0, doneAt = -1;
        bus.md_result = 32'h42; bus.md_exception = 0;
        for (int c = 0; c < 19; c++) begin
            bus.dx_ir = c < 18 ? MULT : NOP;
            bus.md_resultRDY = c == 16;
            @(negedge clock);
            pulses += int'(bus.ctrl_MULT);
            busy += int'(bus.md_busy);
            if (bus.pw_valid) doneAt = c;
            if (c == 0 || c == 1 || c == 17) begin
                checks++;
                if (act !== (c == 0 ? SMUL : c == 1 ? WAIT : FIN)) begin
                    errors++; $display("FAIL mult_ctl[%0d]: ctl=%b", c, act);
                end
            end
            if (c == 17) begin
                checks++;
                if (bus.pw_result !== 32'h42 || bus.pw_exception !== 1'b0) begin
                    errors++; $display("FAIL mult_result: pw=%h exc=%b expected 42/0", bus.pw_result, bus.pw_exception);
                end
            end
            tick();
        end
        bus.md_resultRDY = 0;
        checks++;
        if (pulses != 1 || busy != 17 || doneAt != 17) begin
            errors++; $display("FAIL mult_timing: pulses=%0d busy=%0d done=%0d expected 1/17/17", pulses, busy, doneAt);
        end
    endtask

    task automatic test_div_zero();
        bus.md_result = 32'h0; bus.md_exception = 1;
        for (int c = 0; c < 6; c++) begin
            bus.dx_ir = c < 5 ? DIV : NOP;
            bus.md_resultRDY = c == 3;
            @(negedge clock);
            if (c == 0) begin
                checks++;
                if (act !== SDIV) begin errors++; $display("FAIL div_start: ctl=%b expected %b", act, SDIV); end
            end
            if (c == 4) begin
                checks++;
                if (act !== FIN || bus.pw_exception !== 1'b1) begin
                    errors++; $display("FAIL div_zero: ctl=%b exc=%b expected %b/1", act, bus.pw_exception, FIN);
                end
            end
            tick();
        end
        bus.md_resultRDY = 0; bus.md_exception = 0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] want [6];
        want = '{SMUL, WAIT, FIN, SDIV, WAIT, FIN};
        for (int c = 0; c < 6; c++) begin
            bus.dx_ir = c < 3 ? MULT : DIV;
            bus.md_resultRDY = c == 1 || c == 4;
            bus.md_result = c == 1 ? 32'h11 : 32'h22;
            @(negedge clock);
            checks++;
            if (act !== want[c]) begin errors++; $display("FAIL back_to_back[%0d]: ctl=%b expected %b", c, act, want[c]); end
            tick();
        end
        bus.dx_ir = NOP; bus.md_resultRDY = 0;
        @(negedge clock);
        checks++;
        if (bus.pw_result !== 32'h22 || bus.pw_exception !== 1'b0 || act !== ZERO) begin
            errors++; $display("FAIL back_to_back_result: pw=%h exc=%b ctl=%b expected 22/0/%b", bus.pw_result, bus.pw_exception, act, ZERO);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        bus.dx_ir = MULT;
        for (int c = 0; c < 5; c++) tick();
        reset = 1; bus.dx_ir = NOP;
        tick();
        reset = 0;
        @(negedge clock);
        checks++;
        if (act !== ZERO || bus.pw_result !== 32'd0 || bus.pw_exception !== 1'b0) begin
            errors++; $display("FAIL reset_busy: ctl=%b pw=%h exc=%b expected %b/0/0", act, bus.pw_result, bus.pw_exception, ZERO);
        end
        tick();
    endtask

`ifdef HAZARD_MD_TIMEOUT_EN
    task automatic test_timeout();
        for (int run = 0; run < 2; run++) begin
            bus.md_result = run == 0 ? 32'h77 : 32'h55;
            for (int c = 0; c < 67; c++) begin
                bus.dx_ir = c < 66 ? MULT : NOP;
                bus.md_resultRDY = run == 0 && c == 64;
                @(negedge clock);
                if (c == 64) begin
                    checks++;
                    if (act !== WAIT) begin errors++; $display("FAIL timeout_wait[%0d]: ctl=%b expected %b", run, act, WAIT); end
                end
                if (c == 65) begin
                    checks++;
                    if (act !== FIN || bus.pw_result !== (run == 0 ? 32'h77 : 32'h0) || bus.pw_exception !== (run == 0 ? 1'b0 : 1'b1)) begin
                        errors++; $display("FAIL timeout_done[%0d]: ctl=%b pw=%h exc=%b", run, act, bus.pw_result, bus.pw_exception);
                    end
                end
                tick();
            end
        end
        bus.md_resultRDY = 0;
    endtask
`else
    task automatic test_no_timeout();
        bus.dx_ir = MULT; bus.md_resultRDY = 0; bus.md_result = 32'h99;
        repeat (101) tick();
        @(negedge clock);
        checks++;
        if (act !== WAIT) begin errors++; $display("FAIL no_timeout: ctl=%b expected %b", act, WAIT); end
        bus.md_resultRDY = 1;
        tick();
        bus.md_resultRDY = 0; bus.dx_ir = NOP;
        @(negedge clock);
        checks++;
        if (act !== FIN || bus.pw_result !== 32'h99) begin
            errors++; $display("FAIL no_timeout_done: ctl=%b pw=%h expected %b/99", act, bus.pw_result, FIN);
        end
        tick();
    endtask
`endif

    function automatic logic [31:0] randIr();
        return mkIr(OPS[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
    endfunction

    task automatic test_random();
        logic [8:0] e;
        for (int i = 0; i < 3000; i++) begin
            bus.fd_ir = randIr();
            bus.dx_ir = randIr();
            bus.flush = $urandom_range(0, 7) == 0;
            bus.md_resultRDY = $urandom_range(0, 4) == 0;
            bus.md_result = $urandom;
            bus.md_exception = 1'($urandom_range(0, 1));
            reset = $urandom_range(0, 199) == 0;
            @(negedge clock);
            e = expCtl();
            checks++;
            if (act !== e || bus.pw_result !== mPwRes || bus.pw_exception !== mPwExc) begin
                errors++;
                $display("FAIL random[%0d]: ctl=%b pw=%h exc=%b expected ctl=%b pw=%h exc=%b",
                         i, act, bus.pw_result, bus.pw_exception, e, mPwRes, mPwExc);
            end
            tick();
        end
        reset = 0; bus.flush = 0; bus.md_resultRDY = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_exempt();
        test_mult();
        test_div_zero();
        test_back_to_back();
        test_reset_busy();
`ifdef HAZARD_MD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall.md
# hazard_stall

Pipeline hazard and stall controller for the 5-stage processor. It decodes the instructions in the F/D and D/X latches and produces the PC, F/D and D/X hold signals and bubble-inject signals. It also sequences the multi-cycle mult/div unit through a small FSM and latches its result into a P/W holding register. It sits directly upstream of the bypass unit: it decides what enters D/X and X/M, and the bypass unit then forwards operands into what it admitted.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears FSM, counter, P/W register.
- fd_ir  in  32  instruction in F/D latch.
- dx_ir  in  32  instruction in D/X latch.
- flush  in  1  branch/jump taken in execute; F/D instruction is squashed this cycle.
- md_resultRDY  in  1  mult/div result valid.
- md_result  in  32  mult/div result.
- md_exception  in  1  mult/div overflow / divide-by-zero.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold F/D latch.
- stall_dx  out  1  hold D/X latch.
- nop_dx  out  1  load zero (nop) into D/X on this edge.
- nop_xm  out  1  load zero (nop) into X/M on this edge.
- ctrl_MULT  out  1  one-cycle start pulse to multdiv.
- ctrl_DIV  out  1  one-cycle start pulse to multdiv.
- pw_result  out  32  registered mult/div result.
- pw_exception  out  1  registered exception flag.
- pw_valid  out  1  execute stage must select pw_result instead of the ALU output.
- md_busy  out  1  FSM not in IDLE.

## Operation
- Field decode:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
  - R-type is opcode 00000. mult is ALU op 00110; div is ALU op 00111.
  - lw is opcode 01000.
- Source registers of fd_ir:
  - rs for every instruction.
  - rt for R-type.
  - rd for sw (00111), bne (00010), blt (00110) and jr (00100).
- Load-use hazard, active only in IDLE:
  - Condition: dx_ir is lw, dx rd ≠ 0, and dx rd equals a source register of fd_ir.
  - Response: stall_pc=1, stall_fd=1, nop_dx=1 for one cycle.
  - Exception: if fd_ir is sw and the match is only on its rd (the store data), no stall. The memory-stage bypass covers it.
  - flush=1 suppresses the load-use stall, because the F/D instruction is squashed anyway.
- FSM states IDLE, BUSY, DONE.
  - IDLE, dx_ir is mult or div:
    - Assert ctrl_MULT or ctrl_DIV for this cycle only.
    - Assert stall_pc, stall_fd, stall_dx and nop_xm.
    - Next state: BUSY.
  - BUSY:
    - Same four stalls asserted; no start pulse.
    - If md_resultRDY=1: latch md_result and md_exception into the pw registers; next state DONE.
  - DONE:
    - All stalls deasserted; pw_valid=1.
    - The mult/div instruction advances to X/M carrying pw_result.
    - Start detection is suppressed this cycle.
    - Next state: IDLE.
- md_busy = (state ≠ IDLE).
- md_resultRDY is ignored outside BUSY.
- flush is ignored while BUSY. No younger branch can be in execute during that state.

## Timing
- Reset values:
  - Every output is 0; state is IDLE; counter is 0.
  - pw_result is 0x00000000.
- Stall and nop outputs are combinational from the current state and the current fd_ir/dx_ir.
- pw_* are registered. pw_valid is a decode of state == DONE.
- Mult/div latency:
  - Start in cycle T. Ready first seen in BUSY cycle T+k.
  - DONE occurs in cycle T+k+1; the instruction leaves D/X at the end of that cycle.
  - Minimum k is 1.
- Back-to-back mult/div: DONE is followed by IDLE, and the next mult/div in D/X starts in that IDLE cycle. There is no double pulse on the same instruction.
- Reset asserted while in BUSY: the next state is IDLE, all outputs go to 0, and the pw registers clear.

## Configuration
- HAZARD_MD_TIMEOUT_EN defined:
  - A 6-bit counter is cleared on entry to BUSY and increments every BUSY cycle.
  - If the counter reaches 63 with md_resultRDY still 0, the next state is DONE with pw_result=0 and pw_exception=1.
  - If md_resultRDY=1 in the same cycle the counter reaches 63, the real result wins.
- HAZARD_MD_TIMEOUT_EN not defined: no counter; BUSY waits indefinitely for md_resultRDY.

## Test plan
- Load-use stall:
  - Stimulus: dx_ir = lw r5,0(r1); fd_ir = add r3,r5,r2.
  - Response: one cycle of stall_pc/stall_fd/nop_dx = 1.
  - Same stimulus with flush=1: all stall outputs 0.
- Store-data exemption and r0:
  - dx_ir = lw r5; fd_ir = sw r5,0(r2) → no stall.
  - dx_ir = lw r0; fd_ir reads r0 → no stall.
- Mult sequence:
  - Stimulus: dx_ir = mult r4,r2,r3; md_resultRDY rises 16 cycles later with md_result = 0x0000_0042.
  - Response: ctrl_MULT high for exactly one cycle, md_busy for 17 cycles, then one DONE cycle with pw_valid=1 and pw_result = 0x42.
- Div by zero: md_exception=1 arrives with the result → pw_exception=1 in the DONE cycle.
- Reset mid-BUSY: assert reset 5 cycles into BUSY → next cycle is IDLE, all outputs 0, pw_result = 0.
- Timeout, with HAZARD_MD_TIMEOUT_EN defined and ready never asserted → DONE after 64 BUSY cycles with pw_exception=1 and pw_result=0.
